// File: rtl/arm_level_sequencer.sv
// Sweeps the six inverter-arm levels one at a time toward a snapshot of the
// requested targets, limiting each step and handing every change to the gate-drive stage.
module arm_level_sequencer #(
    parameter int LEVEL_W    = 7,
    parameter int MAX_LEVEL  = 127,
    parameter int MAX_STEP   = 1,
    parameter int INIT_LEVEL = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [6*LEVEL_W-1:0] tgt_data,
    output logic [6*LEVEL_W-1:0] lvl_out,
    output logic                 upd_valid,
    output logic [2:0]           upd_arm,
    output logic [LEVEL_W-1:0]   upd_level,
    input  logic                 upd_ready,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          sweep_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_NEXT,
        S_DONE
    } state_e;

    localparam int                 NUM_ARMS  = 6;
    localparam logic [LEVEL_W:0]   MAX_LVL_X = (LEVEL_W+1)'(MAX_LEVEL);
    localparam logic [LEVEL_W:0]   MAX_STP_X = (LEVEL_W+1)'(MAX_STEP);
    localparam logic [LEVEL_W-1:0] INIT_LVL  = LEVEL_W'(INIT_LEVEL);

    state_e               state_q, state_d;
    logic [2:0]           arm_q, arm_d;
    logic [LEVEL_W-1:0]   shadow_q [NUM_ARMS];
    logic [LEVEL_W-1:0]   shadow_d [NUM_ARMS];
    logic [LEVEL_W-1:0]   cur_q    [NUM_ARMS];
    logic [LEVEL_W-1:0]   cur_d    [NUM_ARMS];
    logic [LEVEL_W-1:0]   new_q, new_d;
    logic [15:0]          sweep_cnt_q, sweep_cnt_d;

    // One extra bit so the clamp and the signed-free step math cannot wrap.
    logic [LEVEL_W:0] tgt_x, cur_x, diff_x, step_x, nxt_x;

    always_comb begin
        tgt_x  = {1'b0, shadow_q[arm_q]};
        cur_x  = {1'b0, cur_q[arm_q]};
        if (tgt_x > MAX_LVL_X) begin
            tgt_x = MAX_LVL_X;
        end
        diff_x = (tgt_x > cur_x) ? (tgt_x - cur_x) : (cur_x - tgt_x);
        step_x = (diff_x > MAX_STP_X) ? MAX_STP_X : diff_x;
        nxt_x  = (tgt_x > cur_x) ? (cur_x + step_x) : (cur_x - step_x);
    end

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path can infer a latch.
        state_d     = state_q;
        arm_d       = arm_q;
        shadow_d    = shadow_q;
        cur_d       = cur_q;
        new_d       = new_q;
        sweep_cnt_d = sweep_cnt_q;
        upd_valid   = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    for (int k = 0; k < NUM_ARMS; k++) begin
                        shadow_d[k] = tgt_data[k*LEVEL_W +: LEVEL_W];
                    end
                    arm_d   = 3'd0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (tgt_x == cur_x) begin
                    state_d = S_NEXT;
                end else begin
                    new_d   = nxt_x[LEVEL_W-1:0];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                upd_valid = 1'b1;
                if (upd_ready) begin
                    cur_d[arm_q] = new_q;
                    state_d      = S_NEXT;
                end
            end
            S_NEXT: begin
                if (arm_q == 3'd5) begin
                    state_d = S_DONE;
                end else begin
                    arm_d   = arm_q + 3'd1;
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                sweep_cnt_d = sweep_cnt_q + 16'd1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Cancel wins over everything, including a handshake in the same cycle.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            cur_d       = cur_q;
            sweep_cnt_d = sweep_cnt_q;
            done        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            arm_q       <= 3'd0;
            new_q       <= '0;
            sweep_cnt_q <= 16'd0;
            // NOTE: the level array is reset element by element because its reset value is observable on lvl_out.
            for (int k = 0; k < NUM_ARMS; k++) begin
                cur_q[k]    <= INIT_LVL;
                shadow_q[k] <= '0;
            end
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            arm_q       <= arm_d;
            new_q       <= new_d;
            sweep_cnt_q <= sweep_cnt_d;
            cur_q       <= cur_d;
            shadow_q    <= shadow_d;
        end
    end

    always_comb begin
        lvl_out = '0;
        for (int k = 0; k < NUM_ARMS; k++) begin
            lvl_out[k*LEVEL_W +: LEVEL_W] = cur_q[k];
        end
    end

    assign upd_arm   = arm_q;
    assign upd_level = new_q;
    assign busy      = (state_q != S_IDLE);
    assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_arm_level_sequencer.sv
// Directed bench for arm_level_sequencer: a default 7-bit instance and a widened
// 8-bit instance with a full-range step, checked against hand-computed values.
`timescale 1ns/1ps
module tb_arm_level_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        start_a, abort_a, upd_ready_a, upd_valid_a, busy_a, done_a;
    logic [41:0] tgt_a, lvl_a;
    logic [2:0]  upd_arm_a;
    logic [6:0]  upd_level_a;
    logic [15:0] cnt_a;

    logic        start_b, abort_b, upd_ready_b, upd_valid_b, busy_b, done_b;
    logic [47:0] tgt_b, lvl_b;
    logic [2:0]  upd_arm_b;
    logic [7:0]  upd_level_b;
    logic [15:0] cnt_b;

    arm_level_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .tgt_data(tgt_a), .lvl_out(lvl_a), .upd_valid(upd_valid_a),
        .upd_arm(upd_arm_a), .upd_level(upd_level_a), .upd_ready(upd_ready_a),
        .busy(busy_a), .done(done_a), .sweep_cnt(cnt_a)
    );

    arm_level_sequencer #(
        .LEVEL_W(8), .MAX_LEVEL(127), .MAX_STEP(127), .INIT_LEVEL(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .tgt_data(tgt_b), .lvl_out(lvl_b), .upd_valid(upd_valid_b),
        .upd_arm(upd_arm_b), .upd_level(upd_level_b), .upd_ready(upd_ready_b),
        .busy(busy_b), .done(done_b), .sweep_cnt(cnt_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int log_arm[$];
    int log_lvl[$];
    int dc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] pk7(input int l0, l1, l2, l3, l4, l5);
        return {7'(l5), 7'(l4), 7'(l3), 7'(l2), 7'(l1), 7'(l0)};
    endfunction

    function automatic logic [47:0] pk8(input int l0, l1, l2, l3, l4, l5);
        return {8'(l5), 8'(l4), 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    // Runs one sweep from an IDLE negedge and logs every handshake. Optional
    // stall (ready low for stall_n cycles on stall_arm), abort on the handshake
    // of abort_arm, or async reset during ISSUE of rst_arm (instance A only).
    // Returns with done_cyc = cycle index of the done pulse (cycle 1 follows the start edge).
    task automatic sweep(input bit sel, input int stall_arm, input int stall_n, input int stall_lvl,
                         input int abort_arm, input int rst_arm, input bit scramble,
                         output int done_cyc);
        int  stalls;
        bit  finished;
        bit  v, r;
        int  arm, lvl;
        log_arm.delete();
        log_lvl.delete();
        done_cyc = 0;
        stalls   = 0;
        finished = 1'b0;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        if (scramble) tgt_a = '0;
        for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
            v   = sel ? upd_valid_b : upd_valid_a;
            arm = sel ? int'(upd_arm_b) : int'(upd_arm_a);
            lvl = sel ? int'(upd_level_b) : int'(upd_level_a);
            if (sel ? done_b : done_a) begin
                done_cyc = cyc;
                finished = 1'b1;
            end else if (v && arm == rst_arm) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_busy", busy_a, 0);
                check("rst_mid_done", done_a, 0);
                check("rst_mid_valid", upd_valid_a, 0);
                check("rst_mid_arm", upd_arm_a, 0);
                check("rst_mid_level", upd_level_a, 0);
                check("rst_mid_cnt", cnt_a, 0);
                check("rst_mid_lvl", lvl_a, 0);
                finished = 1'b1;
            end else begin
                r = 1'b1;
                if (v && arm == stall_arm) begin
                    check("stall_level_stable", lvl, stall_lvl);
                    if (stalls < stall_n) begin
                        r = 1'b0;
                        stalls++;
                    end
                end
                if (v && arm == abort_arm) begin
                    abort_a  = 1'b1;
                    finished = 1'b1;
                end else if (v && r) begin
                    log_arm.push_back(arm);
                    log_lvl.push_back(lvl);
                end
                if (sel) upd_ready_b = r; else upd_ready_a = r;
                @(negedge clk);
                abort_a     = 1'b0;
                upd_ready_a = 1'b1;
                upd_ready_b = 1'b1;
            end
        end
        if (!finished) check("sweep_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_arm[5];
        int exp_lvl[5];
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; upd_ready_a = 1'b1; tgt_a = '0;
        start_b = 1'b0; abort_b = 1'b0; upd_ready_b = 1'b1; tgt_b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_valid", upd_valid_a, 0);
        check("reset_arm", upd_arm_a, 0);
        check("reset_level", upd_level_a, 0);
        check("reset_cnt", cnt_a, 0);
        check("reset_lvl", lvl_a, 0);
        check("reset_lvl_b", lvl_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All targets zero: no update, done in cycle 13, idle in cycle 14.
        sweep(0, -1, 0, 0, -1, -1, 0, dc);
        check("nochg_done_cycle", dc, 13);
        check("nochg_updates", log_arm.size(), 0);
        check("nochg_busy_in_done", busy_a, 1);
        @(negedge clk);
        check("nochg_busy_after", busy_a, 0);
        check("nochg_done_after", done_a, 0);
        check("nochg_cnt", cnt_a, 1);
        check("nochg_lvl", lvl_a, 0);

        // start together with abort in IDLE stays idle.
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        check("start_abort_busy", busy_a, 0);
        @(negedge clk);
        check("start_abort_busy2", busy_a, 0);

        // Unit steps toward a_up=3 and c_dw=5.
        tgt_a = pk7(3, 0, 0, 0, 0, 5);
        for (int s = 1; s <= 3; s++) begin
            sweep(0, -1, 0, 0, -1, -1, 0, dc);
            check("step_done_cycle", dc, 15);
            check("step_n_updates", log_arm.size(), 2);
            if (log_arm.size() == 2) begin
                check("step_arm_first", log_arm[0], 0);
                check("step_lvl_first", log_lvl[0], s);
                check("step_arm_second", log_arm[1], 5);
                check("step_lvl_second", log_lvl[1], s);
            end
            @(negedge clk);
        end
        check("step_lvl_after3", lvl_a, pk7(3, 0, 0, 0, 0, 3));
        sweep(0, -1, 0, 0, -1, -1, 0, dc);
        check("step4_done_cycle", dc, 14);
        check("step4_n_updates", log_arm.size(), 1);
        if (log_arm.size() == 1) begin
            check("step4_arm", log_arm[0], 5);
            check("step4_lvl", log_lvl[0], 4);
        end
        @(negedge clk);
        check("step_lvl_after4", lvl_a, pk7(3, 0, 0, 0, 0, 4));
        check("step_cnt", cnt_a, 5);

        // Back-pressure: ready low 5 cycles on arm 1 stretches a 14-cycle sweep to 19.
        tgt_a = pk7(3, 1, 0, 0, 0, 4);
        sweep(0, 1, 5, 1, -1, -1, 0, dc);
        check("stall_done_cycle", dc, 19);
        check("stall_n_updates", log_arm.size(), 1);
        if (log_arm.size() == 1) begin
            check("stall_arm", log_arm[0], 1);
            check("stall_lvl", log_lvl[0], 1);
        end
        @(negedge clk);
        check("stall_lvl_out", lvl_a, pk7(3, 1, 0, 0, 0, 4));
        check("stall_cnt", cnt_a, 6);

        // Wide instance: full-range step up, full-range step down, then clamping.
        tgt_b = pk8(0, 0, 127, 0, 0, 0);
        sweep(1, -1, 0, 0, -1, -1, 0, dc);
        check("wide_up_done_cycle", dc, 14);
        check("wide_up_n", log_arm.size(), 1);
        if (log_arm.size() == 1) begin
            check("wide_up_arm", log_arm[0], 2);
            check("wide_up_lvl", log_lvl[0], 127);
        end
        @(negedge clk);
        check("wide_up_lvl_out", lvl_b, pk8(0, 0, 127, 0, 0, 0));
        tgt_b = '0;
        sweep(1, -1, 0, 0, -1, -1, 0, dc);
        check("wide_dn_n", log_arm.size(), 1);
        if (log_arm.size() == 1) begin
            check("wide_dn_arm", log_arm[0], 2);
            check("wide_dn_lvl", log_lvl[0], 0);
        end
        @(negedge clk);
        check("wide_dn_lvl_out", lvl_b, 0);
        tgt_b = pk8(0, 0, 200, 0, 255, 0);
        sweep(1, -1, 0, 0, -1, -1, 0, dc);
        check("clamp_done_cycle", dc, 15);
        check("clamp_n", log_arm.size(), 2);
        if (log_arm.size() == 2) begin
            check("clamp_arm_first", log_arm[0], 2);
            check("clamp_lvl_first", log_lvl[0], 127);
            check("clamp_arm_second", log_arm[1], 4);
            check("clamp_lvl_second", log_lvl[1], 127);
        end
        @(negedge clk);
        check("clamp_lvl_out", lvl_b, pk8(0, 0, 127, 0, 127, 0));
        check("clamp_cnt", cnt_b, 3);

        // Abort on the arm-3 handshake: arms 0..2 keep their steps, arm 3 does not move.
        tgt_a = pk7(4, 2, 1, 1, 0, 4);
        sweep(0, -1, 0, 0, 3, -1, 0, dc);
        check("abort_no_done_seen", dc, 0);
        check("abort_busy_next", busy_a, 0);
        check("abort_done_next", done_a, 0);
        check("abort_n_updates", log_arm.size(), 3);
        check("abort_cnt", cnt_a, 6);
        check("abort_lvl_out", lvl_a, pk7(4, 2, 1, 0, 0, 4));
        @(negedge clk);
        check("abort_busy_later", busy_a, 0);

        // Reset during ISSUE of arm 4.
        tgt_a = pk7(4, 2, 1, 0, 3, 4);
        sweep(0, -1, 0, 0, -1, 4, 0, dc);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy_a, 0);

        // Counter at 0xFFFF wraps on the next completed sweep; the sweep starts at arm 0
        // and ignores the target being cleared mid-sweep.
        force dut_a.sweep_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut_a.sweep_cnt_q;
        @(negedge clk);
        check("preload_cnt", cnt_a, 16'hFFFF);
        exp_arm = '{0, 1, 2, 4, 5};
        exp_lvl = '{1, 1, 1, 1, 1};
        sweep(0, -1, 0, 0, -1, -1, 1, dc);
        check("wrap_done_cycle", dc, 18);
        check("wrap_n_updates", log_arm.size(), 5);
        if (log_arm.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("wrap_arm", log_arm[i], exp_arm[i]);
                check("wrap_lvl", log_lvl[i], exp_lvl[i]);
            end
        end
        @(negedge clk);
        check("wrap_cnt", cnt_a, 0);
        check("wrap_lvl_out", lvl_a, pk7(1, 1, 1, 0, 1, 1));
        check("wrap_busy", busy_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
